// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the core's pipeline control.
// Memory-stage FSM encoding, the zero register, default timeout.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned TIMEOUT_DEF = 15;

endpackage

// File: rtl/hazard_unit.sv
// Load-use detection and priority selection of pipeline enables.
// Mem stall beats branch flush, which beats the load-use bubble.
module hazard_unit
    import cpu_ctrl_pkg::*;
(
    input  logic       mem_stall_i,
    input  logic       branch_taken_i,
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    output logic       pc_en_o,
    output logic       ifid_en_o,
    output logic       idex_en_o,
    output logic       exmem_en_o,
    output logic       memwb_en_o,
    output logic       idex_bubble_o,
    output logic       ifid_flush_o
);

    logic load_use;

    assign load_use = idex_mem_read_i
                    && (idex_rt_i != REG_ZERO)
                    && ((idex_rt_i == ifid_rs_i)
                     || (idex_rt_i == ifid_rt_i));

    // Priority mux of freeze / flush / bubble controls
    always_comb begin
        pc_en_o       = 1'b1;
        ifid_en_o     = 1'b1;
        idex_en_o     = 1'b1;
        exmem_en_o    = 1'b1;
        memwb_en_o    = 1'b1;
        idex_bubble_o = 1'b0;
        ifid_flush_o  = 1'b0;
        if (mem_stall_i) begin
            pc_en_o    = 1'b0;
            ifid_en_o  = 1'b0;
            idex_en_o  = 1'b0;
            exmem_en_o = 1'b0;
            memwb_en_o = 1'b0;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end else if (load_use) begin
            pc_en_o       = 1'b0;
            ifid_en_o     = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: req/ack to data memory with timeout,
// stall accounting, and pipeline enable generation.
module mem_stage_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exmem_mem_read,
    input  logic              exmem_mem_write,
    input  logic [DATA_W-1:0] exmem_addr,
    input  logic [DATA_W-1:0] exmem_wdata,
    input  logic              idex_mem_read,
    input  logic [4:0]        idex_rt,
    input  logic [4:0]        ifid_rs,
    input  logic [4:0]        ifid_rt,
    input  logic              branch_taken,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] load_data,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    mem_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ld_q, ld_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              access;
    logic              mem_stall;
    logic [TO_W-1:0]   to_inc;
    logic              to_hit;

    assign access    = exmem_mem_read | exmem_mem_write;
    assign mem_stall = ((state_q == IDLE) && access)
                     || (state_q == REQ);
    assign to_inc    = to_q + TO_W'(1);
    assign to_hit    = (TIMEOUT != 0)
                     && (to_inc == TO_W'(TIMEOUT));

    // Next-state and registered memory-side values
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        err_d   = err_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    addr_d  = exmem_addr;
                    wdata_d = exmem_wdata;
                    we_d    = exmem_mem_write;
                    req_d   = 1'b1;
                    to_d    = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) ld_d = dmem_rdata;
                    state_d = DONE;
                end else begin
                    to_d = to_inc;
                    if (to_hit) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        ld_d    = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Saturating count of frozen cycles
    always_comb begin
        cnt_d = cnt_q;
        if (mem_stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            err_q   <= 1'b0;
            to_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign load_data   = ld_q;
    assign timeout_err = err_q;
    assign stall_cnt   = cnt_q;

    hazard_unit u_hazard (
        .mem_stall_i     (mem_stall),
        .branch_taken_i  (branch_taken),
        .idex_mem_read_i (idex_mem_read),
        .idex_rt_i       (idex_rt),
        .ifid_rs_i       (ifid_rs),
        .ifid_rt_i       (ifid_rt),
        .pc_en_o         (pc_en),
        .ifid_en_o       (ifid_en),
        .idex_en_o       (idex_en),
        .exmem_en_o      (exmem_en),
        .memwb_en_o      (memwb_en),
        .idex_bubble_o   (idex_bubble),
        .ifid_flush_o    (ifid_flush)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: per-cycle model compare plus
// directed literal checks along the scripted scenarios.
module tb_mem_stage_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exmem_mem_read, exmem_mem_write;
    logic [31:0] exmem_addr, exmem_wdata;
    logic        idex_mem_read;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        branch_taken, dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, load_data;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        idex_bubble, ifid_flush, timeout_err;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    mem_stage_ctrl #(.TIMEOUT(TO), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .exmem_mem_read(exmem_mem_read),
        .exmem_mem_write(exmem_mem_write),
        .exmem_addr(exmem_addr), .exmem_wdata(exmem_wdata),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .branch_taken(branch_taken),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .load_data(load_data),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .timeout_err(timeout_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Model: an access is either absent (0), waiting on memory
    // (1, with waited cycles), or just finished (2).
    int          m_phase = 0;
    int          m_waited = 0;
    logic        e_req = 0, e_we = 0, e_err = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_ld = 0;
    int          e_cnt = 0;

    always @(negedge clk) begin
        bit stall, lu, run;
        if (!rst_n) begin
            m_phase = 0; m_waited = 0;
            e_req = 0; e_we = 0; e_err = 0;
            e_addr = 0; e_wdata = 0; e_ld = 0; e_cnt = 0;
            chk("rst_req", {31'd0, dmem_req}, 32'd0);
            chk("rst_we", {31'd0, dmem_we}, 32'd0);
            chk("rst_addr", dmem_addr, 32'd0);
            chk("rst_ld", load_data, 32'd0);
            chk("rst_err", {31'd0, timeout_err}, 32'd0);
            chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        end else begin
            stall = (m_phase == 1)
                 || (m_phase == 0 && (exmem_mem_read || exmem_mem_write));
            lu = idex_mem_read && idex_rt != 0
              && (idex_rt == ifid_rs || idex_rt == ifid_rt);
            run = !stall;
            chk("m_req", {31'd0, dmem_req}, {31'd0, e_req});
            chk("m_we", {31'd0, dmem_we}, {31'd0, e_we});
            chk("m_addr", dmem_addr, e_addr);
            chk("m_wdata", dmem_wdata, e_wdata);
            chk("m_ld", load_data, e_ld);
            chk("m_err", {31'd0, timeout_err}, {31'd0, e_err});
            chk("m_cnt", {16'd0, stall_cnt}, e_cnt);
            chk("m_pc", {31'd0, pc_en},
                {31'd0, run && (branch_taken || !lu)});
            chk("m_ifid", {31'd0, ifid_en},
                {31'd0, run && (branch_taken || !lu)});
            chk("m_idex", {31'd0, idex_en}, {31'd0, run});
            chk("m_exmem", {31'd0, exmem_en}, {31'd0, run});
            chk("m_memwb", {31'd0, memwb_en}, {31'd0, run});
            chk("m_flush", {31'd0, ifid_flush},
                {31'd0, run && branch_taken});
            chk("m_bubble", {31'd0, idex_bubble},
                {31'd0, run && !branch_taken && lu});
            if (stall && e_cnt < 65535) e_cnt++;
            if (m_phase == 2) begin
                m_phase = 0;
            end else if (m_phase == 1) begin
                if (dmem_ack) begin
                    e_req = 0;
                    if (!e_we) e_ld = dmem_rdata;
                    m_phase = 2;
                end else begin
                    m_waited++;
                    if (m_waited == TO) begin
                        e_req = 0; e_err = 1; e_ld = 0;
                        m_phase = 2;
                    end
                end
            end else if (exmem_mem_read || exmem_mem_write) begin
                e_req = 1;
                e_we = exmem_mem_write;
                e_addr = exmem_addr;
                e_wdata = exmem_wdata;
                m_waited = 0;
                m_phase = 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        exmem_mem_read = 0; exmem_mem_write = 0;
        exmem_addr = 0; exmem_wdata = 0;
        idex_mem_read = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        branch_taken = 0; dmem_ack = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("init_pc", {31'd0, pc_en}, 32'd1);
        chk("init_cnt", {16'd0, stall_cnt}, 32'd0);

        // Load, ack in first REQ cycle
        cyc();
        exmem_mem_read = 1; exmem_addr = 32'h40;
        #1 chk("ld_idle_stall", {31'd0, pc_en}, 32'd0);
        cyc();
        chk("ld_req", {31'd0, dmem_req}, 32'd1);
        chk("ld_addr", dmem_addr, 32'h40);
        chk("ld_we", {31'd0, dmem_we}, 32'd0);
        dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
        cyc();
        dmem_ack = 0;
        #1;
        chk("ld_data", load_data, 32'hDEADBEEF);
        chk("ld_done_req", {31'd0, dmem_req}, 32'd0);
        chk("ld_done_en", {31'd0, exmem_en}, 32'd1);
        chk("ld_cnt", {16'd0, stall_cnt}, 32'd2);
        cyc();
        exmem_mem_read = 0;

        // Store, ack in third REQ cycle
        cyc();
        exmem_mem_write = 1; exmem_addr = 32'h80; exmem_wdata = 32'h1234;
        cyc();
        chk("st_we", {31'd0, dmem_we}, 32'd1);
        chk("st_wdata", dmem_wdata, 32'h1234);
        cyc();
        cyc();
        dmem_ack = 1; dmem_rdata = 32'h0BAD0BAD;
        cyc();
        dmem_ack = 0;
        chk("st_keep_ld", load_data, 32'hDEADBEEF);
        chk("st_cnt", {16'd0, stall_cnt}, 32'd6);
        cyc();
        exmem_mem_write = 0;

        // Timeout on a load with no ack
        cyc();
        exmem_mem_read = 1; exmem_addr = 32'hC0;
        repeat (4) cyc();
        chk("to_req4", {31'd0, dmem_req}, 32'd1);
        cyc();
        chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_ld", load_data, 32'd0);
        chk("to_pc", {31'd0, pc_en}, 32'd1);
        chk("to_cnt", {16'd0, stall_cnt}, 32'd11);
        cyc();
        exmem_addr = 32'hC4;
        cyc();
        dmem_ack = 1; dmem_rdata = 32'hA5;
        cyc();
        dmem_ack = 0;
        chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
        chk("to_ld2", load_data, 32'hA5);
        cyc();
        exmem_mem_read = 0;

        // Load-use bubble, and r0 exemption
        cyc();
        idex_mem_read = 1; idex_rt = 5; ifid_rs = 5;
        #1;
        chk("lu_pc", {31'd0, pc_en}, 32'd0);
        chk("lu_bub", {31'd0, idex_bubble}, 32'd1);
        chk("lu_exmem", {31'd0, exmem_en}, 32'd1);
        cyc();
        idex_rt = 0; ifid_rs = 0;
        #1 chk("lu_r0", {31'd0, pc_en}, 32'd1);

        // Branch beats load-use
        cyc();
        idex_rt = 7; ifid_rt = 7; branch_taken = 1;
        #1;
        chk("br_flush", {31'd0, ifid_flush}, 32'd1);
        chk("br_nobub", {31'd0, idex_bubble}, 32'd0);
        cyc();
        idex_mem_read = 0; idex_rt = 0; ifid_rt = 0;

        // Branch held across a mem stall
        exmem_mem_read = 1; exmem_addr = 32'h100;
        #1 chk("brs_idle", {31'd0, ifid_flush}, 32'd0);
        cyc();
        dmem_ack = 1; dmem_rdata = 32'h55;
        #1 chk("brs_req", {31'd0, ifid_flush}, 32'd0);
        cyc();
        dmem_ack = 0;
        #1 chk("brs_done", {31'd0, ifid_flush}, 32'd1);
        cyc();
        exmem_mem_read = 0; branch_taken = 0;

        // Reset in the second REQ cycle
        cyc();
        exmem_mem_read = 1; exmem_addr = 32'h200;
        cyc();
        cyc();
        #1 rst_n = 0;
        #1;
        chk("mr_req", {31'd0, dmem_req}, 32'd0);
        chk("mr_err", {31'd0, timeout_err}, 32'd0);
        cyc();
        rst_n = 1; exmem_mem_read = 0;
        dmem_ack = 1; dmem_rdata = 32'hFFFF;
        #1;
        chk("mr_pc", {31'd0, pc_en}, 32'd1);
        chk("mr_memwb", {31'd0, memwb_en}, 32'd1);
        cyc();
        chk("mr_ack_ign", load_data, 32'd0);
        chk("mr_req2", {31'd0, dmem_req}, 32'd0);
        dmem_ack = 0;
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Pipeline control for the 5-stage core. Sequences each EX/MEM load/store onto a variable-latency data memory through a req/ack handshake.
- Freezes the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers while an access is outstanding.
- Also inserts load-use bubbles and IF/ID flushes on taken branches.
- Sits beside the EX/MEM register: its outputs drive that register's enable, and its memory-side ports drive the data memory.

Parameters:
- TIMEOUT, 15, max REQ-state cycles waiting for dmem_ack; 0 disables the timeout.
- DATA_W, 32, data and address width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- exmem_mem_read  in  1  EX/MEM holds a load.
- exmem_mem_write  in  1  EX/MEM holds a store.
- exmem_addr  in  DATA_W  EX/MEM ALU result (address).
- exmem_wdata  in  DATA_W  EX/MEM store data.
- idex_mem_read  in  1  ID/EX holds a load.
- idex_rt  in  5  ID/EX load destination register.
- ifid_rs  in  5  IF/ID source register rs.
- ifid_rt  in  5  IF/ID source register rt.
- branch_taken  in  1  branch resolved taken this cycle.
- dmem_ack  in  1  memory completes the access.
- dmem_rdata  in  DATA_W  memory read data, valid with ack.
- dmem_req  out  1  access request, registered.
- dmem_we  out  1  1 = write, registered.
- dmem_addr  out  DATA_W  registered address.
- dmem_wdata  out  DATA_W  registered write data.
- load_data  out  DATA_W  captured read data, forwarded to MEM/WB.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID enable.
- idex_en  out  1  ID/EX enable.
- exmem_en  out  1  EX/MEM enable.
- memwb_en  out  1  MEM/WB enable.
- idex_bubble  out  1  load zero controls into ID/EX.
- ifid_flush  out  1  load NOP into IF/ID.
- timeout_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  saturating count of mem-stall cycles.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, load_data, timeout_err, stall_cnt and the timeout counter all 0. Combinational outputs then evaluate to pc/ifid/idex/exmem/memwb_en=1 unless the hazard terms below apply.
- FSM states: IDLE, REQ, DONE.
  - IDLE: if exmem_mem_read|exmem_mem_write, capture addr, wdata and we=exmem_mem_write into dmem_*, set dmem_req=1, clear the timeout counter, go to REQ.
  - REQ: dmem_req held at 1.
    - dmem_ack=1: dmem_req←0; load_data←dmem_rdata if it is a read (unchanged on a write); go to DONE.
    - Otherwise the counter increments. When it reaches TIMEOUT (TIMEOUT≠0): dmem_req←0, timeout_err←1, load_data←0, go to DONE.
  - DONE: unconditionally go to IDLE. EX/MEM does not re-trigger here, because the pipeline advances at this edge.
- dmem_ack is ignored outside REQ.
- If read and write are both asserted, the access is treated as a write.
- mem_stall = (IDLE & (exmem_mem_read|exmem_mem_write)) | REQ.
- Latency: ack in the first REQ cycle gives 2 stall cycles, and the instruction leaves EX/MEM at the end of DONE. Each extra ack-wait cycle adds 1 stall.
- load_use = idex_mem_read & idex_rt≠0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- Output priority:
  1. mem_stall: all five enables =0; ifid_flush=0; idex_bubble=0. A pending branch_taken/load_use is re-evaluated after the stall, since the stages are frozen.
  2. branch_taken: ifid_flush=1; all enables=1; idex_bubble=0. The flush supersedes load_use.
  3. load_use: pc_en=0; ifid_en=0; idex_bubble=1; other enables=1. Lasts exactly one cycle because the load moves to EX/MEM.
  4. Otherwise all enables=1; flush=0; bubble=0.
- stall_cnt increments each cycle mem_stall=1 and saturates at all-ones.
- timeout_err is cleared only by reset.
- Reset mid-REQ: dmem_req drops immediately (asynchronous) and no ack is consumed afterwards.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - FSM state enum (IDLE=2'd0, REQ=2'd1, DONE=2'd2);
  - REG_ZERO=5'd0;
  - default TIMEOUT constant.
- One sub-module, hazard_unit: purely combinational load_use detection and priority muxing of the enables. The FSM, counters and registers remain in mem_stage_ctrl.

Test Plan:
- Load, ack in 1st REQ cycle, rdata=32'hDEADBEEF, addr=32'h40 → dmem_req high 1 cycle with addr 32'h40 and we=0; enables low 2 cycles; load_data=32'hDEADBEEF in DONE; stall_cnt=2.
- Store, addr 32'h80, wdata 32'h1234, ack after 3 REQ cycles → we=1, wdata 32'h1234; 4 stall cycles; load_data unchanged.
- TIMEOUT=4, no ack → req drops after 4 REQ cycles; timeout_err=1; load_data=0; pipeline resumes in DONE; err stays 1 through later accesses.
- idex_mem_read=1, idex_rt=5, ifid_rs=5 → one cycle pc_en=0, ifid_en=0, idex_bubble=1. Same with idex_rt=0 → no stall.
- Same cycle: load_use and branch_taken → ifid_flush=1, no bubble. Then branch_taken during a mem stall → flush=0 until the stall ends, then flush=1 for one cycle.
- rst_n pulsed low in the 2nd REQ cycle → dmem_req=0 immediately; state IDLE; late ack ignored; all enables=1 after release with idle inputs.
